// File: rtl/synth_pkg.sv
// Shared synth types and constants: envelope state encoding, level limits and
// the rate-code to step mapping.
package synth_pkg;

   localparam int unsigned LEVEL_W = 16;
   localparam int unsigned RATE_W  = 8;
   localparam int unsigned ENV_W   = 8;

   localparam logic [LEVEL_W-1:0] LEVEL_MAX = 16'hFFFF;
   localparam logic [LEVEL_W-1:0] STEP_MIN  = 16'h0010;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } env_state_t;

   // Rate 0x00 -> 0x0010, rate 0xFF -> 0x1000.
   function automatic logic [LEVEL_W-1:0] calc_step(input logic [RATE_W-1:0] rate);
      return {4'h0, rate, 4'h0} + STEP_MIN;
   endfunction

endpackage

// File: rtl/gate_edge_detect.sv
// Registers the key gate once per clk and flags its rising and falling edges.
module gate_edge_detect (
   input  logic clk,
   input  logic nRst,
   input  logic gate,
   output logic rise,
   output logic fall
);

   logic gate_q;

   // Cleared in reset so a gate held high through reset release reads as a rise.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) gate_q <= 1'b0;
      else       gate_q <= gate;
   end

   assign rise = gate & ~gate_q;
   assign fall = ~gate & gate_q;

endmodule

// File: rtl/envelope_generator.sv
// ADSR envelope generator: 16-bit level stepped on each sample tick, with gate
// edges retriggering attack or starting release.
module envelope_generator
   import synth_pkg::*;
(
   input  logic              clk,
   input  logic              nRst,
   input  logic              sample_now,
   input  logic              gate,
   input  logic [RATE_W-1:0] attack_rate,
   input  logic [RATE_W-1:0] decay_rate,
   input  logic [ENV_W-1:0]  sustain_level,
   input  logic [RATE_W-1:0] release_rate,
   output logic [ENV_W-1:0]  env_level,
   output logic              env_valid,
   output logic [2:0]        env_state
);

   env_state_t          state_q, state_d;
   logic [LEVEL_W-1:0]  level_q, level_d;
   logic [ENV_W-1:0]    env_level_q;
   logic                env_valid_q;

   logic                rise, fall;
   logic [RATE_W-1:0]   rate;
   logic [LEVEL_W-1:0]  step;
   logic [LEVEL_W-1:0]  target;
   logic [LEVEL_W:0]    sum_ext, diff_ext, target_ext;

   gate_edge_detect u_gate_edge_detect (
      .clk  (clk),
      .nRst (nRst),
      .gate (gate),
      .rise (rise),
      .fall (fall)
   );

   // Per-state rate selection and the 17-bit arithmetic shared by all states.
   always_comb begin
      rate = '0;
      unique case (state_q)
         ST_ATTACK:  rate = attack_rate;
         ST_DECAY:   rate = decay_rate;
         ST_RELEASE: rate = release_rate;
         default:    rate = '0;
      endcase
      step       = calc_step(rate);
      target     = {sustain_level, 8'h00};
      sum_ext    = {1'b0, level_q} + {1'b0, step};
      diff_ext   = {1'b0, level_q} - {1'b0, step};
      target_ext = {1'b0, target};
   end

   // Gate edges win over the sample tick: state moves, level holds.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      if (rise) begin
         state_d = ST_ATTACK;
      end else if (fall) begin
         if (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN)
            state_d = ST_RELEASE;
      end else if (sample_now) begin
         unique case (state_q)
            ST_ATTACK: begin
               if (sum_ext >= {1'b0, LEVEL_MAX}) begin
                  level_d = LEVEL_MAX;
                  state_d = ST_DECAY;
               end else begin
                  level_d = sum_ext[LEVEL_W-1:0];
               end
            end
            ST_DECAY: begin
               if ($signed(diff_ext) <= $signed(target_ext)) begin
                  level_d = target;
                  state_d = ST_SUSTAIN;
               end else begin
                  level_d = diff_ext[LEVEL_W-1:0];
               end
            end
            ST_SUSTAIN: level_d = target;
            ST_RELEASE: begin
               if (diff_ext[LEVEL_W] || (diff_ext == '0)) begin
                  level_d = '0;
                  state_d = ST_IDLE;
               end else begin
                  level_d = diff_ext[LEVEL_W-1:0];
               end
            end
            default: level_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q     <= ST_IDLE;
         level_q     <= '0;
         env_level_q <= '0;
         env_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         env_valid_q <= sample_now;
         if (sample_now) env_level_q <= level_d[LEVEL_W-1 -: ENV_W];
      end
   end

   assign env_level = env_level_q;
   assign env_valid = env_valid_q;
   assign env_state = state_q;

endmodule
